// File: rtl/interrupt_controller_if.sv
// Register-bus interface of the interrupt controller: word select,
// read/write strobes, write data and the combinational read data.
interface interrupt_controller_if;
    logic [1:0]  I_addr;
    logic        I_wen;
    logic        I_ren;
    logic [31:0] I_wdata;
    logic [31:0] O_rdata;

    // Bus owner (CPU side) drives address, strobes and write data.
    modport master (
        output I_addr,
        output I_wen,
        output I_ren,
        output I_wdata,
        input  O_rdata
    );

    // The controller samples the request and returns read data.
    modport slave (
        input  I_addr,
        input  I_wen,
        input  I_ren,
        input  I_wdata,
        output O_rdata
    );
endinterface

// File: rtl/interrupt_controller.sv
// Interrupt controller: NSRC synchronised interrupt lines with per-source
// enable and edge/level mode, lowest-index priority and a claim/complete
// handshake. A single source can be in service at a time.
module interrupt_controller #(
    parameter int NSRC = 8
) (
    input  logic                  I_clk,
    input  logic                  I_rst,
    input  logic [NSRC-1:0]       I_irq,
    interrupt_controller_if.slave bus,
    output logic                  O_extinterrupt
);

    localparam int ID_W = 5;

    localparam logic [1:0] ADDR_ENABLE  = 2'd0;
    localparam logic [1:0] ADDR_PENDING = 2'd1;
    localparam logic [1:0] ADDR_MODE    = 2'd2;
    localparam logic [1:0] ADDR_CLAIM   = 2'd3;

    // Architectural and synchroniser state.
    logic [NSRC-1:0] sync1_q, sync2_q, prev_q;
    logic [NSRC-1:0] enable_q, enable_d;
    logic [NSRC-1:0] mode_q, mode_d;
    logic [NSRC-1:0] pending_q, pending_d;
    logic            busy_q, busy_d;
    logic [ID_W-1:0] in_service_q, in_service_d;
    logic            ext_irq_q, ext_irq_d;

    // Combinational helpers.
    logic [NSRC-1:0] claimable;
    logic            winner_found;
    logic [ID_W-1:0] winner_idx;
    logic            complete;
    logic            busy_eff;
    logic [ID_W-1:0] claim_id;
    logic            claim_take;
    logic [NSRC-1:0] claim_mask;
    logic [NSRC-1:0] in_service_mask;
    logic [NSRC-1:0] edge_set, level_set;

    // Only the low write-data bits reach a register; the rest are don't-care.
    logic unused_wdata;
    assign unused_wdata = ^bus.I_wdata;

    assign claimable = pending_q & enable_q;

    // Priority pick: scanning downwards leaves the lowest claimable index.
    always_comb begin
        // NOTE: every variable gets a default before any conditional
        // assignment so this block can never infer a latch.
        winner_found = 1'b0;
        winner_idx   = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (claimable[i]) begin
                winner_found = 1'b1;
                winner_idx   = ID_W'(i);
            end
        end
    end

    // Complete is resolved before the claim, so a same-cycle read sees busy=0.
    always_comb begin
        complete   = bus.I_wen && (bus.I_addr == ADDR_CLAIM) && busy_q &&
                     (bus.I_wdata[ID_W-1:0] == in_service_q);
        busy_eff   = busy_q && !complete;
        claim_id   = (winner_found && !busy_eff) ? winner_idx + ID_W'(1) : '0;
        claim_take = bus.I_ren && (bus.I_addr == ADDR_CLAIM) && (claim_id != '0);
    end

    // Next busy/in-service state and the per-source masks derived from it.
    always_comb begin
        busy_d       = busy_eff;
        in_service_d = in_service_q;
        if (claim_take) begin
            busy_d       = 1'b1;
            in_service_d = claim_id;
        end
        for (int i = 0; i < NSRC; i++) begin
            claim_mask[i]      = claim_take && (winner_idx == ID_W'(i));
            in_service_mask[i] = busy_d && (in_service_d == ID_W'(i + 1));
        end
    end

    // Pending update: a new request always wins over a same-cycle claim clear.
    // A level source being claimed (or already in service) does not re-pend.
    always_comb begin
        edge_set  = sync2_q & ~prev_q & mode_q;
        level_set = sync2_q & ~mode_q & ~in_service_mask;
        pending_d = (pending_q & ~claim_mask) | edge_set | level_set;
        ext_irq_d = (|claimable) && !busy_q;
    end

    // ENABLE / MODE register writes; PENDING is read-only.
    always_comb begin
        enable_d = enable_q;
        mode_d   = mode_q;
        if (bus.I_wen) begin
            case (bus.I_addr)
                ADDR_ENABLE: enable_d = bus.I_wdata[NSRC-1:0];
                ADDR_MODE:   mode_d   = bus.I_wdata[NSRC-1:0];
                default:     ;
            endcase
        end
    end

    // Read mux: all-ones when idle, unmapped bits read as zero.
    always_comb begin
        bus.O_rdata = '1;
        if (bus.I_ren) begin
            bus.O_rdata = '0;
            case (bus.I_addr)
                ADDR_ENABLE:  bus.O_rdata[NSRC-1:0] = enable_q;
                ADDR_PENDING: bus.O_rdata[NSRC-1:0] = pending_q;
                ADDR_MODE:    bus.O_rdata[NSRC-1:0] = mode_q;
                default:      bus.O_rdata[ID_W-1:0] = claim_id;
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge I_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge value of every other register.
        if (I_rst) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            prev_q       <= '0;
            enable_q     <= '0;
            mode_q       <= '0;
            pending_q    <= '0;
            busy_q       <= 1'b0;
            in_service_q <= '0;
            ext_irq_q    <= 1'b0;
        end else begin
            sync1_q      <= I_irq;
            sync2_q      <= sync1_q;
            prev_q       <= sync2_q;
            enable_q     <= enable_d;
            mode_q       <= mode_d;
            pending_q    <= pending_d;
            busy_q       <= busy_d;
            in_service_q <= in_service_d;
            ext_irq_q    <= ext_irq_d;
        end
    end

    assign O_extinterrupt = ext_irq_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller: expected values are queued
// as each stimulus is driven and compared when the DUT output is sampled.
module tb_interrupt_controller;

    localparam int NSRC = 8;

    logic            I_clk = 1'b0;
    logic            I_rst;
    logic [NSRC-1:0] I_irq;
    logic            O_extinterrupt;

    interrupt_controller_if bus ();

    interrupt_controller #(.NSRC(NSRC)) dut (
        .I_clk          (I_clk),
        .I_rst          (I_rst),
        .I_irq          (I_irq),
        .bus            (bus),
        .O_extinterrupt (O_extinterrupt)
    );

    always #5 I_clk = ~I_clk;

    typedef struct {
        string       tag;
        logic [31:0] value;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic pop_check(input logic [31:0] actual);
        exp_t e;
        e = exp_q.pop_front();
        check(e.tag, actual, e.value);
    endtask

    // One bus cycle: inputs change on the falling edge, outputs are
    // sampled 1 time unit later, well clear of the next rising edge.
    task automatic cycle(input logic [1:0] a, input logic w, input logic r,
                         input logic [31:0] d);
        @(negedge I_clk);
        bus.I_addr  = a;
        bus.I_wen   = w;
        bus.I_ren   = r;
        bus.I_wdata = d;
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(2'd0, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        cycle(a, 1'b1, 1'b0, d);
    endtask

    task automatic expect_cycle(input string tag, input logic [1:0] a,
                                input logic w, input logic r,
                                input logic [31:0] d, input logic [31:0] val);
        exp_q.push_back('{tag, val});
        cycle(a, w, r, d);
        pop_check(bus.O_rdata);
    endtask

    task automatic expect_rd(input string tag, input logic [1:0] a,
                             input logic [31:0] val);
        expect_cycle(tag, a, 1'b0, 1'b1, 32'd0, val);
    endtask

    task automatic expect_ext(input string tag, input logic val);
        exp_q.push_back('{tag, {31'd0, val}});
        pop_check({31'd0, O_extinterrupt});
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        I_rst       = 1'b1;
        I_irq       = '0;
        bus.I_addr  = 2'd0;
        bus.I_wen   = 1'b0;
        bus.I_ren   = 1'b0;
        bus.I_wdata = 32'd0;
        idle(3);
        I_rst = 1'b0;
        idle(1);

        // Reset state and idle read value.
        expect_rd("rst_enable", 2'd0, 32'h0);
        expect_rd("rst_pending", 2'd1, 32'h0);
        expect_rd("rst_mode", 2'd2, 32'h0);
        expect_rd("rst_claim", 2'd3, 32'h0);
        expect_ext("rst_ext", 1'b0);
        expect_cycle("idle_rdata", 2'd1, 1'b0, 1'b0, 32'd0, 32'hFFFF_FFFF);

        // Unmapped bits read zero; PENDING ignores writes.
        wr(2'd0, 32'hFFFF_FFFF);
        expect_rd("enable_mask", 2'd0, 32'h0000_00FF);
        wr(2'd1, 32'h0000_00FF);
        expect_rd("pending_ro", 2'd1, 32'h0);
        wr(2'd2, 32'hFFFF_FF01);
        expect_rd("mode_mask", 2'd2, 32'h0000_0001);
        wr(2'd0, 32'h01);

        // Edge source 0, one-cycle pulse: latency and claim.
        cycle(2'd0, 1'b0, 1'b0, 32'd0); I_irq = 8'h01;
        cycle(2'd0, 1'b0, 1'b0, 32'd0); I_irq = 8'h00;
        expect_rd("r31_pend_e1", 2'd1, 32'h0);
        expect_rd("r31_pend_e2", 2'd1, 32'h1);
        expect_ext("r31_ext_e2", 1'b0);
        expect_rd("r31_claim", 2'd3, 32'd1);
        expect_ext("r31_ext_e3", 1'b1);
        expect_rd("r31_claim_busy", 2'd3, 32'd0);
        expect_rd("r31_pending_clr", 2'd1, 32'h0);
        expect_ext("r31_ext_after", 1'b0);
        wr(2'd3, 32'd1);
        expect_rd("r31_claim_empty", 2'd3, 32'd0);

        // Wrong complete ID is ignored while busy with ID 1.
        cycle(2'd0, 1'b0, 1'b0, 32'd0); I_irq = 8'h01;
        cycle(2'd0, 1'b0, 1'b0, 32'd0); I_irq = 8'h00;
        idle(1);
        expect_rd("r34_claim", 2'd3, 32'd1);
        wr(2'd3, 32'd2);
        cycle(2'd0, 1'b0, 1'b0, 32'd0); I_irq = 8'h01;
        cycle(2'd0, 1'b0, 1'b0, 32'd0); I_irq = 8'h00;
        idle(1);
        expect_rd("r34_pending", 2'd1, 32'h1);
        expect_rd("r34_claim_blocked", 2'd3, 32'd0);
        wr(2'd3, 32'd1);
        expect_rd("r34_claim_after", 2'd3, 32'd1);
        wr(2'd3, 32'd1);

        // Claim clear and new edge on the same cycle: the set wins.
        cycle(2'd0, 1'b0, 1'b0, 32'd0); I_irq = 8'h01;
        cycle(2'd0, 1'b0, 1'b0, 32'd0); I_irq = 8'h00;
        idle(2);
        cycle(2'd0, 1'b0, 1'b0, 32'd0); I_irq = 8'h01;
        cycle(2'd0, 1'b0, 1'b0, 32'd0); I_irq = 8'h00;
        expect_rd("r24_claim", 2'd3, 32'd1);
        expect_rd("r24_pending_kept", 2'd1, 32'h1);
        wr(2'd3, 32'd1);
        expect_rd("r24_claim2", 2'd3, 32'd1);
        wr(2'd3, 32'd1);

        // Priority between sources 2 and 5; complete and claim together.
        wr(2'd0, 32'hFF);
        wr(2'd2, 32'hFF);
        cycle(2'd0, 1'b0, 1'b0, 32'd0); I_irq = 8'h24;
        idle(2);
        expect_rd("r32_claim3", 2'd3, 32'd3);
        expect_cycle("r32_cplt3_claim6", 2'd3, 1'b1, 1'b1, 32'd3, 32'd6);
        expect_rd("r32_pending_none", 2'd1, 32'h0);
        expect_cycle("r32_cplt6_claim0", 2'd3, 1'b1, 1'b1, 32'd6, 32'd0);
        I_irq = 8'h00;
        idle(3);

        // Level source 4 held high: no re-pend while in service.
        wr(2'd0, 32'h10);
        wr(2'd2, 32'h00);
        cycle(2'd0, 1'b0, 1'b0, 32'd0); I_irq = 8'h10;
        idle(2);
        expect_rd("r33_claim", 2'd3, 32'd5);
        expect_rd("r33_no_repend", 2'd1, 32'h0);
        idle(2);
        expect_rd("r33_no_repend2", 2'd1, 32'h0);
        expect_ext("r33_ext_busy", 1'b0);
        wr(2'd3, 32'd5);
        expect_rd("r33_repend", 2'd1, 32'h10);
        expect_rd("r33_claim_again", 2'd3, 32'd5);
        expect_ext("r33_ext_again", 1'b1);
        I_irq = 8'h00;
        idle(3);
        wr(2'd3, 32'd5);
        expect_rd("r33_pending_idle", 2'd1, 32'h0);

        // Disabled source still pends; enabling raises the request.
        wr(2'd2, 32'h08);
        wr(2'd0, 32'h00);
        cycle(2'd0, 1'b0, 1'b0, 32'd0); I_irq = 8'h08;
        cycle(2'd0, 1'b0, 1'b0, 32'd0); I_irq = 8'h00;
        idle(1);
        expect_rd("r35_pending", 2'd1, 32'h08);
        idle(1);
        expect_ext("r35_ext_masked", 1'b0);
        wr(2'd0, 32'h08);
        idle(1);
        idle(1);
        expect_ext("r35_ext_enabled", 1'b1);
        wr(2'd0, 32'h00);
        idle(1);
        expect_rd("r26_pending_kept", 2'd1, 32'h08);
        expect_ext("r26_ext_masked", 1'b0);
        wr(2'd0, 32'h08);
        idle(1);
        expect_rd("r26_claim", 2'd3, 32'd4);
        expect_ext("r26_ext_reraised", 1'b1);
        wr(2'd3, 32'd4);

        // Reset in the middle of a claim with more sources pending.
        wr(2'd0, 32'h07);
        wr(2'd2, 32'h07);
        cycle(2'd0, 1'b0, 1'b0, 32'd0); I_irq = 8'h07;
        cycle(2'd0, 1'b0, 1'b0, 32'd0); I_irq = 8'h00;
        idle(1);
        expect_rd("r36_claim", 2'd3, 32'd1);
        expect_rd("r36_pending", 2'd1, 32'h06);
        I_rst = 1'b1;
        idle(2);
        I_rst = 1'b0;
        idle(1);
        expect_rd("r36_enable", 2'd0, 32'h0);
        expect_rd("r36_mode", 2'd2, 32'h0);
        expect_rd("r36_pending0", 2'd1, 32'h0);
        expect_rd("r36_claim0", 2'd3, 32'd0);
        expect_ext("r36_ext", 1'b0);

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
